// File: rtl/i2c_pkg.sv
// i2c_pkg: definitions shared by the I2C target and the I2C write master.
//   state_e  - protocol FSM states. RD_DATA and RD_ACK exist only when the
//              I2C_TARGET_READ_EN macro is defined.
//   COND_*   - bus condition codes: none, START, STOP.
//   bus_cond - classifies the synchronized scl/sda activity in one clock.
package i2c_pkg;

  localparam logic [1:0] COND_NONE  = 2'b00;
  localparam logic [1:0] COND_START = 2'b01;
  localparam logic [1:0] COND_STOP  = 2'b10;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV,
    ST_DEV_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_DATA,
    ST_DATA_ACK
`ifdef I2C_TARGET_READ_EN
    , ST_RD_DATA
    , ST_RD_ACK
`endif
  } state_e;

  // sda may only change while scl is high to signal START or STOP.
  function automatic logic [1:0] bus_cond(input logic scl_hi,
                                          input logic sda_rise,
                                          input logic sda_fall);
    if (scl_hi && sda_fall) return COND_START;
    if (scl_hi && sda_rise) return COND_STOP;
    return COND_NONE;
  endfunction

endpackage

// File: rtl/i2c_sync.sv
// i2c_sync: synchronizer and edge detector for one I2C bus line.
//   clk     in   system clock
//   rst     in   asynchronous active-high reset; every flop resets to 1,
//                which is the idle level of the bus
//   i_async in   raw bus line
//   o_level out  synchronized level
//   o_rise  out  one-clk pulse on a synchronized rising edge
//   o_fall  out  one-clk pulse on a synchronized falling edge
module i2c_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      // shift form keeps the chain legal for STAGES == 1
      r_sync <= (r_sync << 1) | STAGES'(i_async);
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = o_level & ~r_prev;
  assign o_fall  = ~o_level & r_prev;

endmodule

// File: rtl/i2c_target.sv
// i2c_target: I2C register-write target.
// The target decodes DEVICE-address, register-pointer and data bytes and
// emits one wr_valid strobe per data byte. The pointer auto-increments
// through a burst.
// Optional macro I2C_TARGET_READ_EN adds register readback: the rd_addr and
// rd_data ports and the RD_DATA and RD_ACK states.
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   scl      in   bus clock (async)
//   sda_i    in   bus data as seen on the pad
//   sda_oe   out  1 pulls sda low
//   wr_valid out  one-clk write strobe
//   wr_addr  out  register address of the write
//   wr_data  out  data byte of the write
//   rd_addr  out  readback address (read build only)
//   rd_data  in   readback byte (read build only)
//
// state       | meaning
// IDLE        | ignore bus until START
// DEV         | shifting in device address + R/W
// DEV_ACK     | driving ACK for address match
// REG         | shifting in register pointer
// REG_ACK     | driving ACK for pointer byte
// DATA        | shifting in write data
// DATA_ACK    | driving ACK, write strobe issued on entry
// RD_DATA     | driving readback byte MSB first
// RD_ACK      | sampling master ACK/NACK
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [7:0] DEVICE      = 8'h72,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data
`ifdef I2C_TARGET_READ_EN
  ,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data
`endif
);

  logic w_scl_hi, w_scl_rise, w_scl_fall;
  logic w_sda_lvl, w_sda_rise, w_sda_fall;
  logic [1:0] w_cond;

  i2c_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .clk(clk), .rst(rst), .i_async(scl),
    .o_level(w_scl_hi), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
  );

  i2c_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .clk(clk), .rst(rst), .i_async(sda_i),
    .o_level(w_sda_lvl), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
  );

  assign w_cond = bus_cond(w_scl_hi, w_sda_rise, w_sda_fall);

  state_e     r_state, w_state_nxt;
  logic       r_sda_oe, w_sda_oe_nxt;
  logic       r_wr_valid;
  logic [7:0] r_wr_addr, r_wr_data, r_ptr, r_shift;
  logic [2:0] r_bit_cnt;
  logic       r_got8;
  logic       w_wr_fire, w_ptr_load, w_ptr_inc, w_rx_state, w_match;
`ifdef I2C_TARGET_READ_EN
  logic [7:0] r_tx;
  logic       w_tx_load, w_tx_shift;
`endif

  assign w_match = (r_shift[7:1] == DEVICE[7:1]);

`ifdef I2C_TARGET_READ_EN
  assign w_rx_state = (r_state == ST_DEV) || (r_state == ST_REG) ||
                      (r_state == ST_DATA) || (r_state == ST_RD_DATA);
`else
  assign w_rx_state = (r_state == ST_DEV) || (r_state == ST_REG) ||
                      (r_state == ST_DATA);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_sda_oe <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sda_oe <= w_sda_oe_nxt;
    end
  end

  // Byte decisions are taken on the scl falling edge after the 8th rising
  // edge (r_got8), so ACK is driven for exactly the 9th clock low+high.
  always_comb begin
    w_state_nxt  = r_state;
    w_sda_oe_nxt = r_sda_oe;
    w_wr_fire    = 1'b0;
    w_ptr_load   = 1'b0;
    w_ptr_inc    = 1'b0;
`ifdef I2C_TARGET_READ_EN
    w_tx_load    = 1'b0;
    w_tx_shift   = 1'b0;
`endif
    if (w_cond == COND_START) begin
      w_state_nxt  = ST_DEV;
      w_sda_oe_nxt = 1'b0;
    end else if (w_cond == COND_STOP) begin
      w_state_nxt  = ST_IDLE;
      w_sda_oe_nxt = 1'b0;
    end else if (w_scl_fall) begin
      unique case (r_state)
        ST_DEV: if (r_got8) begin
`ifdef I2C_TARGET_READ_EN
          if (w_match) begin
`else
          if (w_match && !r_shift[0]) begin
`endif
            w_state_nxt  = ST_DEV_ACK;
            w_sda_oe_nxt = 1'b1;
          end else begin
            w_state_nxt  = ST_IDLE;
          end
        end
        ST_DEV_ACK: begin
          w_sda_oe_nxt = 1'b0;
          w_state_nxt  = ST_REG;
`ifdef I2C_TARGET_READ_EN
          // no bits are shifted during DEV_ACK, so r_shift[0] is still R/W
          if (r_shift[0]) begin
            w_state_nxt  = ST_RD_DATA;
            w_tx_load    = 1'b1;
            w_sda_oe_nxt = ~rd_data[7];
          end
`endif
        end
        ST_REG: if (r_got8) begin
          w_state_nxt  = ST_REG_ACK;
          w_sda_oe_nxt = 1'b1;
          w_ptr_load   = 1'b1;
        end
        ST_REG_ACK: begin
          w_state_nxt  = ST_DATA;
          w_sda_oe_nxt = 1'b0;
        end
        ST_DATA: if (r_got8) begin
          w_state_nxt  = ST_DATA_ACK;
          w_sda_oe_nxt = 1'b1;
          w_wr_fire    = 1'b1;
          w_ptr_inc    = 1'b1;
        end
        ST_DATA_ACK: begin
          w_state_nxt  = ST_DATA;
          w_sda_oe_nxt = 1'b0;
        end
`ifdef I2C_TARGET_READ_EN
        ST_RD_DATA: begin
          if (r_got8) begin
            w_state_nxt  = ST_RD_ACK;
            w_sda_oe_nxt = 1'b0;
            w_ptr_inc    = 1'b1;
          end else begin
            w_sda_oe_nxt = ~r_tx[6];
            w_tx_shift   = 1'b1;
          end
        end
        ST_RD_ACK: begin
          w_state_nxt  = ST_RD_DATA;
          w_tx_load    = 1'b1;
          w_sda_oe_nxt = ~rd_data[7];
        end
`endif
        default: ;
      endcase
`ifdef I2C_TARGET_READ_EN
    end else if (w_scl_rise && r_state == ST_RD_ACK && w_sda_lvl) begin
      w_state_nxt = ST_IDLE;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_valid <= 1'b0;
      r_wr_addr  <= 8'h00;
      r_wr_data  <= 8'h00;
      r_ptr      <= 8'h00;
      r_shift    <= 8'h00;
      r_bit_cnt  <= 3'd0;
      r_got8     <= 1'b0;
    end else begin
      r_wr_valid <= w_wr_fire;
      if (w_wr_fire) begin
        r_wr_addr <= r_ptr;
        r_wr_data <= r_shift;
      end
      if (w_ptr_load)     r_ptr <= r_shift;
      else if (w_ptr_inc) r_ptr <= r_ptr + 8'd1;
      if (w_cond != COND_NONE) begin
        r_bit_cnt <= 3'd0;
        r_got8    <= 1'b0;
      end else if (w_scl_rise && w_rx_state) begin
        r_shift   <= {r_shift[6:0], w_sda_lvl};
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) r_got8 <= 1'b1;
      end else if (w_scl_fall) begin
        r_got8 <= 1'b0;
      end
    end
  end

`ifdef I2C_TARGET_READ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_tx <= 8'h00;
    else if (w_tx_load)  r_tx <= rd_data;
    else if (w_tx_shift) r_tx <= {r_tx[6:0], 1'b0};
  end
  assign rd_addr = r_ptr;
`endif

  assign sda_oe   = r_sda_oe;
  assign wr_valid = r_wr_valid;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;

endmodule

// File: tb/tb_i2c_target.sv
`timescale 1ns/1ps
module tb_i2c_target;
  import i2c_pkg::*;

  localparam int Q = 80;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       scl   = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_i;
  logic       sda_oe, wr_valid;
  logic [7:0] wr_addr, wr_data;
`ifdef I2C_TARGET_READ_EN
  logic [7:0] rd_addr, rd_data;
  assign rd_data = (rd_addr == 8'h9C) ? 8'h30 : (rd_addr ^ 8'hA5);
`endif

  // open-drain wired-AND of master and target
  assign sda_i = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target dut (
    .clk(clk), .rst(rst), .scl(scl), .sda_i(sda_i), .sda_oe(sda_oe),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data)
`ifdef I2C_TARGET_READ_EN
    , .rd_addr(rd_addr), .rd_data(rd_data)
`endif
  );

  int total = 0;
  int bad   = 0;

  int         wr_cnt = 0;
  int         oe_cnt = 0;
  logic [7:0] log_addr [64];
  logic [7:0] log_data [64];

  always @(negedge clk) begin
    if (wr_valid) begin
      log_addr[wr_cnt % 64] <= wr_addr;
      log_data[wr_cnt % 64] <= wr_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (sda_oe) oe_cnt <= oe_cnt + 1;
  end

  task automatic bus_start;
    sda_m = 1'b1; #Q; scl = 1'b1; #Q; sda_m = 1'b0; #Q; scl = 1'b0; #Q;
  endtask

  task automatic bus_stop;
    sda_m = 1'b0; #Q; scl = 1'b1; #Q; sda_m = 1'b1; #(2*Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
    end
    sda_m = 1'b1; #Q; scl = 1'b1; #Q; ack = ~sda_i; #Q; scl = 1'b0; #Q;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    b = 8'h00;
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      #Q; scl = 1'b1; #Q; b = {b[6:0], sda_i}; #Q; scl = 1'b0;
    end
    #Q; sda_m = nack; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q; sda_m = 1'b1;
  endtask

  task automatic test_reset;
    #50;
    total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL reset_sda_oe got=%b exp=0", sda_oe); end
    total++; if (wr_valid !== 1'b0) begin bad++; $display("FAIL reset_wr_valid got=%b exp=0", wr_valid); end
    total++; if (wr_addr !== 8'h00) begin bad++; $display("FAIL reset_wr_addr got=%h exp=00", wr_addr); end
    total++; if (wr_data !== 8'h00) begin bad++; $display("FAIL reset_wr_data got=%h exp=00", wr_data); end
    total++; if (dut.r_state !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", dut.r_state, ST_IDLE); end
    total++; if (dut.r_ptr !== 8'h00) begin bad++; $display("FAIL reset_ptr got=%h exp=00", dut.r_ptr); end
    rst = 1'b0;
    #(2*Q);
  endtask

  task automatic test_write;
    int base; logic a0, a1, a2;
    base = wr_cnt;
    bus_start;
    write_byte(8'h72, a0); write_byte(8'h98, a1); write_byte(8'h03, a2);
    bus_stop;
    total++; if ({a0, a1, a2} !== 3'b111) begin bad++; $display("FAIL write_acks got=%b exp=111", {a0, a1, a2}); end
    total++; if (wr_cnt - base !== 1) begin bad++; $display("FAIL write_count got=%0d exp=1", wr_cnt - base); end
    total++; if (log_addr[base % 64] !== 8'h98) begin bad++; $display("FAIL write_addr got=%h exp=98", log_addr[base % 64]); end
    total++; if (log_data[base % 64] !== 8'h03) begin bad++; $display("FAIL write_data got=%h exp=03", log_data[base % 64]); end
    total++; if (dut.r_state !== ST_IDLE) begin bad++; $display("FAIL write_stop_idle got=%0d exp=%0d", dut.r_state, ST_IDLE); end
  endtask

  task automatic test_nack;
    int base, obase; logic a0, a1, a2;
    base = wr_cnt; obase = oe_cnt;
    bus_start;
    write_byte(8'h70, a0); write_byte(8'h15, a1); write_byte(8'h00, a2);
    bus_stop;
    total++; if ({a0, a1, a2} !== 3'b000) begin bad++; $display("FAIL nack_acks got=%b exp=000", {a0, a1, a2}); end
    total++; if (wr_cnt - base !== 0) begin bad++; $display("FAIL nack_writes got=%0d exp=0", wr_cnt - base); end
    total++; if (oe_cnt - obase !== 0) begin bad++; $display("FAIL nack_oe_cycles got=%0d exp=0", oe_cnt - obase); end
  endtask

  task automatic test_burst;
    int base; logic a0, a1, a2, a3;
    base = wr_cnt;
    bus_start;
    write_byte(8'h72, a0); write_byte(8'hFF, a1); write_byte(8'h11, a2); write_byte(8'h22, a3);
    bus_stop;
    total++; if ({a0, a1, a2, a3} !== 4'b1111) begin bad++; $display("FAIL burst_acks got=%b exp=1111", {a0, a1, a2, a3}); end
    total++; if (wr_cnt - base !== 2) begin bad++; $display("FAIL burst_count got=%0d exp=2", wr_cnt - base); end
    total++; if ({log_addr[base % 64], log_data[base % 64]} !== 16'hFF11) begin bad++;
      $display("FAIL burst_w0 got=%h/%h exp=ff/11", log_addr[base % 64], log_data[base % 64]); end
    total++; if ({log_addr[(base + 1) % 64], log_data[(base + 1) % 64]} !== 16'h0022) begin bad++;
      $display("FAIL burst_w1 got=%h/%h exp=00/22", log_addr[(base + 1) % 64], log_data[(base + 1) % 64]); end
  endtask

  task automatic test_reset_mid;
    int base; logic a0, a1, a2;
    logic [7:0] b;
    base = wr_cnt;
    b = 8'hC3;
    bus_start;
    write_byte(8'h72, a0); write_byte(8'h55, a1);
    for (int i = 7; i >= 4; i--) begin
      sda_m = b[i]; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
    end
    sda_m = 1'b1;
    rst = 1'b1; #Q;
    total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL rstmid_sda_oe got=%b exp=0", sda_oe); end
    total++; if (dut.r_state !== ST_IDLE) begin bad++; $display("FAIL rstmid_state got=%0d exp=%0d", dut.r_state, ST_IDLE); end
    rst = 1'b0; #Q;
    for (int i = 3; i >= 0; i--) begin
      sda_m = b[i]; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
    end
    bus_stop;
    total++; if (wr_cnt - base !== 0) begin bad++; $display("FAIL rstmid_no_write got=%0d exp=0", wr_cnt - base); end
    bus_start;
    write_byte(8'h72, a0); write_byte(8'h41, a1); write_byte(8'h10, a2);
    bus_stop;
    total++; if ({a0, a1, a2} !== 3'b111) begin bad++; $display("FAIL rstmid_acks got=%b exp=111", {a0, a1, a2}); end
    total++; if (wr_cnt - base !== 1) begin bad++; $display("FAIL rstmid_count got=%0d exp=1", wr_cnt - base); end
    total++; if ({log_addr[base % 64], log_data[base % 64]} !== 16'h4110) begin bad++;
      $display("FAIL rstmid_write got=%h/%h exp=41/10", log_addr[base % 64], log_data[base % 64]); end
  endtask

  task automatic test_rep_start;
    int base; logic a0, a1, a2, a3, a4;
    base = wr_cnt;
    bus_start;
    write_byte(8'h72, a0); write_byte(8'hAF, a1);
    bus_start;
    write_byte(8'h72, a2); write_byte(8'h16, a3); write_byte(8'h70, a4);
    bus_stop;
    total++; if ({a0, a1, a2, a3, a4} !== 5'b11111) begin bad++; $display("FAIL rstart_acks got=%b exp=11111", {a0, a1, a2, a3, a4}); end
    total++; if (wr_cnt - base !== 1) begin bad++; $display("FAIL rstart_count got=%0d exp=1", wr_cnt - base); end
    total++; if ({log_addr[base % 64], log_data[base % 64]} !== 16'h1670) begin bad++;
      $display("FAIL rstart_write got=%h/%h exp=16/70", log_addr[base % 64], log_data[base % 64]); end
  endtask

`ifdef I2C_TARGET_READ_EN
  task automatic test_read;
    int base; logic a0, a1, a2; logic [7:0] rb;
    base = wr_cnt;
    bus_start;
    write_byte(8'h72, a0); write_byte(8'h9C, a1);
    bus_start;
    write_byte(8'h73, a2);
    read_byte(1'b1, rb);
    total++; if ({a0, a1, a2} !== 3'b111) begin bad++; $display("FAIL read_acks got=%b exp=111", {a0, a1, a2}); end
    total++; if (rb !== 8'h30) begin bad++; $display("FAIL read_data got=%h exp=30", rb); end
    total++; if (dut.r_state !== ST_IDLE) begin bad++; $display("FAIL read_nack_idle got=%0d exp=%0d", dut.r_state, ST_IDLE); end
    bus_stop;
    total++; if (wr_cnt - base !== 0) begin bad++; $display("FAIL read_no_write got=%0d exp=0", wr_cnt - base); end
  endtask
`else
  task automatic test_read_rejected;
    int obase; logic a0;
    obase = oe_cnt;
    bus_start;
    write_byte(8'h73, a0);
    total++; if (a0 !== 1'b0) begin bad++; $display("FAIL rd_addr_nack got=%b exp=0", a0); end
    total++; if (dut.r_state !== ST_IDLE) begin bad++; $display("FAIL rd_addr_idle got=%0d exp=%0d", dut.r_state, ST_IDLE); end
    bus_stop;
    total++; if (oe_cnt - obase !== 0) begin bad++; $display("FAIL rd_addr_oe got=%0d exp=0", oe_cnt - obase); end
  endtask
`endif

  initial begin
    #2;
    test_reset;
    test_write;
    test_nack;
    test_burst;
    test_reset_mid;
    test_rep_start;
`ifdef I2C_TARGET_READ_EN
    test_read;
`else
    test_read_rejected;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
